// File: rtl/paramest_nn_dense_pkg.sv
// Shared types and constant helpers for the ParamEst_NN dense-layer accumulator.
package paramest_nn_dense_pkg;

  // Accumulator FSM: collect products, finalise the sum, present the result.
  typedef enum logic [1:0] {
    ACC = 2'd0,
    FIN = 2'd1,
    OUT = 2'd2
  } state_t;

  // Ceiling log2 (clog2(1) = 0), usable in constant expressions.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width that holds N_IN worst-case products plus the shifted bias without overflow.
  function automatic int acc_w_calc(input int n_in, input int prod_w,
                                    input int bias_w, input int shift);
    return max2(prod_w, bias_w + shift) + clog2(n_in + 1) + 1;
  endfunction

  // Two's-complement range limits of an out_w-bit signed result.
  function automatic longint sat_hi(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

  // Bounds for the default 16-bit activation format.
  localparam int     OUT_W_DEFAULT  = 16;
  localparam longint SAT_HI_DEFAULT = sat_hi(OUT_W_DEFAULT);
  localparam longint SAT_LO_DEFAULT = sat_lo(OUT_W_DEFAULT);

endpackage

// File: rtl/paramest_nn_dense_acc_if.sv
// Product input stream and activation output stream of the dense accumulator.
interface paramest_nn_dense_acc_if #(
  parameter int PROD_W = 26,
  parameter int OUT_W  = 16
);
  logic [PROD_W-1:0] prod_tdata;
  logic              prod_tvalid;
  logic              prod_tready;
  logic              prod_tlast;
  logic [OUT_W-1:0]  out_tdata;
  logic              out_tvalid;
  logic              out_tready;

  // Upstream multiplier / downstream buffer side.
  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, out_tready,
    input  prod_tready, out_tdata, out_tvalid
  );

  // Accumulator side.
  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, out_tready,
    output prod_tready, out_tdata, out_tvalid
  );
endinterface

// File: rtl/paramest_nn_dense_acc_round_sat.sv
// Combinational round-half-up, optional ReLU and saturation of the biased sum.
module paramest_nn_round_sat
  import paramest_nn_dense_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int SHIFT = 10,
  parameter int OUT_W = 16,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] s,
  output logic signed [OUT_W-1:0] out
);
  // One guard bit so adding the rounding constant can never wrap.
  localparam int EW = ACC_W + 1;
  localparam logic signed [EW-1:0] HALF = EW'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [EW-1:0] HI   = EW'(sat_hi(OUT_W));
  localparam logic signed [EW-1:0] LO   = EW'(sat_lo(OUT_W));

  logic signed [EW-1:0] s_ext;
  logic signed [EW-1:0] s_rnd;
  logic signed [EW-1:0] r_shift;
  logic signed [EW-1:0] r_relu;

  // Round, rectify, then clamp into the output range.
  always_comb begin
    s_ext   = {s[ACC_W-1], s};
    s_rnd   = s_ext + HALF;
    r_shift = s_rnd >>> SHIFT;
    if ((RELU != 0) && r_shift[EW-1]) begin
      r_relu = '0;
    end else begin
      r_relu = r_shift;
    end
    if (r_relu > HI) begin
      out = OUT_W'(HI);
    end else if (r_relu < LO) begin
      out = OUT_W'(LO);
    end else begin
      out = OUT_W'(r_relu);
    end
  end

endmodule

// File: rtl/paramest_nn_dense_acc.sv
// Dense-layer neuron accumulator: sums N_IN products, adds bias, rounds/ReLU/saturates.
module paramest_nn_dense_acc
  import paramest_nn_dense_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int PROD_W = 26,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 10,
  parameter int RELU   = 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  paramest_nn_dense_acc_if.slave   axis,
  input  logic signed [BIAS_W-1:0] bias,
  output logic                     frame_err
);
  localparam int ACC_W = acc_w_calc(N_IN, PROD_W, BIAS_W, SHIFT);
  localparam int CNT_W = clog2(N_IN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  state_t                   state_reg;
  state_t                   state_next;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic signed [OUT_W-1:0]  out_reg;
  logic                     err_reg;

  logic                     prod_ready;
  logic                     beat;
  logic                     last_beat;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_sh;
  logic signed [ACC_W-1:0]  sum_fin;
  logic signed [OUT_W-1:0]  rs_out;

  // Ready only while collecting, and never while reset is asserted.
  assign prod_ready       = (state_reg == ACC) && !ap_rst;
  assign axis.prod_tready = prod_ready;
  assign beat             = axis.prod_tvalid && prod_ready;
  assign last_beat        = (cnt_reg == LAST_CNT);
  assign axis.out_tvalid  = (state_reg == OUT);
  assign axis.out_tdata   = out_reg;
  assign frame_err        = err_reg;

  // Sign-extend the product and align the bias to the product's fixed point.
  assign prod_ext = {{(ACC_W - PROD_W){axis.prod_tdata[PROD_W-1]}}, axis.prod_tdata};
  assign bias_sh  = {{(ACC_W - BIAS_W - SHIFT){bias[BIAS_W-1]}}, bias, {SHIFT{1'b0}}};
  assign sum_fin  = acc_reg + bias_sh;

  paramest_nn_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W),
    .RELU  (RELU)
  ) u_round_sat (
    .s   (sum_fin),
    .out (rs_out)
  );

  // Next-state logic: count-based framing, tlast is only checked.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACC: if (beat && last_beat) state_next = FIN;
      FIN: state_next = OUT;
      OUT: if (axis.out_tready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= ACC;
    end else begin
      state_reg <= state_next;
    end
  end

  // Accumulator and beat counter; cleared when the result is taken.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (beat) begin
      acc_reg <= acc_reg + prod_ext;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if ((state_reg == OUT) && axis.out_tready) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end
  end

  // Result register, loaded once per frame and held through backpressure.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_reg <= '0;
    end else if (state_reg == FIN) begin
      out_reg <= rs_out;
    end
  end

  // One-cycle pulse when tlast disagrees with the beat position.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= beat && (axis.prod_tlast != last_beat);
    end
  end

endmodule

// File: tb/tb_paramest_nn_dense_acc.sv
// Scoreboard bench: two accumulators (RELU=1 and RELU=0) fed identical streams.
module tb_paramest_nn_dense_acc;
  localparam int N_IN   = 16;
  localparam int PROD_W = 26;
  localparam int BIAS_W = 16;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 10;
  localparam logic [N_IN-1:0] LAST_MASK = {1'b1, {(N_IN-1){1'b0}}};

  logic clk = 1'b0;
  logic rst;
  logic signed [BIAS_W-1:0] bias;
  logic ferr1, ferr0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  int last_cyc = 0;
  bit rand_bp = 1'b0;
  longint prods[N_IN];
  longint q1[$];
  longint q0[$];

  paramest_nn_dense_acc_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus1 ();
  paramest_nn_dense_acc_if #(.PROD_W(PROD_W), .OUT_W(OUT_W)) bus0 ();

  paramest_nn_dense_acc #(.N_IN(N_IN), .PROD_W(PROD_W), .BIAS_W(BIAS_W),
                          .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(1)) u_dut1 (
    .ap_clk(clk), .ap_rst(rst), .axis(bus1.slave), .bias(bias), .frame_err(ferr1));

  paramest_nn_dense_acc #(.N_IN(N_IN), .PROD_W(PROD_W), .BIAS_W(BIAS_W),
                          .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(0)) u_dut0 (
    .ap_clk(clk), .ap_rst(rst), .axis(bus0.slave), .bias(bias), .frame_err(ferr0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor((sum + bias*2^SHIFT + 2^(SHIFT-1)) / 2^SHIFT), ReLU, clamp.
  function automatic longint model(input longint sum, input longint b, input bit relu);
    longint d, s, q;
    d = longint'(1) <<< SHIFT;
    s = sum + b * d + d / 2;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic drive_prod(input longint d, input logic v, input logic l);
    bus1.prod_tdata = PROD_W'(d);
    bus0.prod_tdata = PROD_W'(d);
    bus1.prod_tvalid = v;
    bus0.prod_tvalid = v;
    bus1.prod_tlast = l;
    bus0.prod_tlast = l;
  endtask

  task automatic set_ready(input logic r);
    bus1.out_tready = r;
    bus0.out_tready = r;
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < N_IN; i++) prods[i] = v;
  endtask

  // Sends n_beats products from prods[]; a full frame also checks output latency.
  task automatic send_frame(input logic [N_IN-1:0] tl_mask, input int max_gap,
                            input bit push, input int n_beats);
    longint sum;
    bit bad;
    int budget;
    sum = 0;
    for (int i = 0; i < N_IN; i++) sum += prods[i];
    if (push) begin
      q1.push_back(model(sum, longint'(bias), 1'b1));
      q0.push_back(model(sum, longint'(bias), 1'b0));
    end
    for (int i = 0; i < n_beats; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          drive_prod(0, 1'b0, 1'b0);
          @(posedge clk); #1;
        end
      end
      drive_prod(prods[i], 1'b1, tl_mask[i]);
      budget = 200;
      while (budget > 0) begin
        @(negedge clk);
        if (bus1.prod_tready === 1'b1) break;
        budget--;
      end
      if (budget == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted, required within 200 cycles", i);
      end
      @(posedge clk); #1;
      drive_prod(0, 1'b0, 1'b0);
      bad = (tl_mask[i] != (i == N_IN - 1));
      if (bad) ferr_exp++;
      check("frame_err_relu1", ferr1, bad);
      check("frame_err_relu0", ferr0, bad);
      if (i == N_IN - 1) begin
        last_cyc = cyc;
        check("fin_valid_low", bus1.out_tvalid, 0);
        @(posedge clk); #1;
        check("out_valid_high", bus1.out_tvalid, 1);
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    while ((q1.size() != 0 || q0.size() != 0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_relu1_pending", q1.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output handshake, counts frame_err pulses.
  always @(negedge clk) begin
    longint e;
    if (ferr1 === 1'b1) ferr_seen++;
    if (rst === 1'b0 && bus1.out_tvalid && bus1.out_tready) begin
      if (q1.size() == 0) begin
        check("relu1_unexpected_output", $signed(bus1.out_tdata), 64'sd99999);
      end else begin
        e = q1.pop_front();
        $display("out relu=1 data=%0d exp=%0d", $signed(bus1.out_tdata), e);
        check("relu1_result", $signed(bus1.out_tdata), e);
      end
    end
    if (rst === 1'b0 && bus0.out_tvalid && bus0.out_tready) begin
      if (q0.size() == 0) begin
        check("relu0_unexpected_output", $signed(bus0.out_tdata), 64'sd99999);
      end else begin
        e = q0.pop_front();
        $display("out relu=0 data=%0d exp=%0d", $signed(bus0.out_tdata), e);
        check("relu0_result", $signed(bus0.out_tdata), e);
      end
    end
  end

  // Random output backpressure, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_bp) set_ready(1'($urandom_range(0, 1)));
    end
  end

  initial begin
    int c0;
    longint e;
    logic [PROD_W-1:0] rv;
    int mode;
    logic [N_IN-1:0] mask;

    rst = 1'b1;
    bias = '0;
    drive_prod(0, 1'b0, 1'b0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_prod_tready", bus1.prod_tready, 0);
    check("reset_out_tvalid", bus1.out_tvalid, 0);
    check("reset_out_tdata", bus1.out_tdata, 0);
    check("reset_frame_err", ferr1, 0);
    rst = 1'b0;
    #1;
    check("post_reset_prod_tready", bus1.prod_tready, 1);

    // Basic sum and back-to-back throughput.
    fill(1024);
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    c0 = last_cyc;
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    check("throughput_cycles", last_cyc - c0, N_IN + 2);

    // Negative results.
    fill(-1024);
    send_frame(LAST_MASK, 0, 1'b1, N_IN);

    // Bias and rounding.
    fill(0);
    bias = 16'sd3;
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    bias = '0;
    prods[5] = 512;
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    prods[5] = 511;
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    prods[5] = -512;
    send_frame(LAST_MASK, 0, 1'b1, N_IN);

    // Saturation.
    fill((longint'(1) <<< 25) - 1);
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    fill(-(longint'(1) <<< 25));
    send_frame(LAST_MASK, 0, 1'b1, N_IN);

    // Backpressure: result held stable for 5 cycles, input stalled.
    drain();
    set_ready(1'b0);
    fill(3000);
    send_frame(LAST_MASK, 0, 1'b1, N_IN);
    e = model(16 * 3000, 0, 1'b1);
    repeat (5) begin
      check("bp_out_tvalid", bus1.out_tvalid, 1);
      check("bp_out_tdata", $signed(bus1.out_tdata), e);
      check("bp_prod_tready", bus1.prod_tready, 0);
      @(posedge clk); #1;
    end
    set_ready(1'b1);

    // Random valid gaps, then the same frame gapless.
    for (int i = 0; i < N_IN; i++) prods[i] = longint'($urandom_range(0, 8191)) - 4096;
    send_frame(LAST_MASK, 3, 1'b1, N_IN);
    send_frame(LAST_MASK, 0, 1'b1, N_IN);

    // Reset after 7 beats discards the partial sum.
    fill(1024);
    send_frame(LAST_MASK, 0, 1'b0, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_prod_tready", bus1.prod_tready, 0);
    rst = 1'b0;
    send_frame(LAST_MASK, 0, 1'b1, N_IN);

    // Reset during OUT drops the pending result.
    drain();
    set_ready(1'b0);
    send_frame(LAST_MASK, 0, 1'b0, N_IN);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("outreset_out_tvalid", bus1.out_tvalid, 0);
    check("outreset_out_tdata", bus1.out_tdata, 0);
    set_ready(1'b1);
    send_frame(LAST_MASK, 0, 1'b1, N_IN);

    // Early tlast on beat 8: one pulse, result still after beat 16.
    drain();
    c0 = ferr_seen;
    send_frame(LAST_MASK | 16'h0080, 0, 1'b1, N_IN);
    drain();
    check("tlast_single_pulse", ferr_seen - c0, 1);

    // Randomised frames with random gaps, bias, backpressure and framing errors.
    rand_bp = 1'b1;
    for (int f = 0; f < 40; f++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N_IN; i++) begin
        rv = PROD_W'($urandom);
        if (mode == 0) prods[i] = longint'($urandom_range(0, 8191)) - 4096;
        else if (mode == 1) prods[i] = longint'($signed(rv));
        else prods[i] = longint'($urandom_range(0, 2047)) - 1024;
      end
      bias = BIAS_W'($urandom);
      mask = LAST_MASK;
      if ($urandom_range(0, 4) == 0) mask = mask ^ (N_IN'(1) << $urandom_range(0, N_IN - 1));
      send_frame(mask, $urandom_range(0, 2), 1'b1, N_IN);
    end
    rand_bp = 1'b0;
    @(posedge clk); #3;
    set_ready(1'b1);
    drain();
    check("final_relu0_pending", q0.size(), 0);
    check("frame_err_pulse_total", ferr_seen, ferr_exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
